seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
- Transmitter side of the 2-bit symbol stream consumed by the team's 01→10→11 sequence detector.
- On a start request, drives `num` with one or more frames of the form 01×L1, 10×L2, 11×L3.
- Frames are optionally separated by idle 00 gap symbols.
- Used as the stimulus source and loop-back partner for the detector.

Parameters:
- CW, 4, width of the per-phase length inputs and internal phase counter.
- FW, 4, width of the frame-count input and frame counter.
- GAP_LEN, 2, number of 00 symbols inserted between consecutive frames (0 = back-to-back frames).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a burst; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE without a done pulse.
- len1  input  CW  number of 01 symbols per frame.
- len2  input  CW  number of 10 symbols per frame.
- len3  input  CW  number of 11 symbols per frame.
- frames  input  FW  number of frames per burst.
- num  output  2  symbol stream, registered.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse after the last symbol of a burst.

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, num=00, busy=0, done=0, and clears all counters. This applies mid-burst too; no done pulse is produced. Leaving reset, the block sits in IDLE.
- All outputs are registered and change only on posedge clk, or on the asynchronous reset.
- States: IDLE, P1, P2, P3, GAP.
- IDLE: num=00, busy=0.
  - If start=1 at edge k: latch len1/len2/len3/frames into internal registers.
  - A latched length of 0 is replaced by 1, and frames=0 is replaced by 1.
  - At edge k: go to P1, num=01, busy=1. The first 01 is therefore visible in cycle k+1.
- Input changes while busy are ignored. start while busy is ignored; it is not queued.
- P1: emits 01 for exactly L1 cycles, then goes to P2 with num=10.
- P2: emits 10 for exactly L2 cycles, then goes to P3 with num=11.
- P3: emits 11 for exactly L3 cycles. At the end of P3:
  - If frames remain and GAP_LEN>0: go to GAP with num=00.
  - If frames remain and GAP_LEN=0: go directly to P1 with num=01.
  - If this was the last frame: go to IDLE with num=00, busy=0, done=1 for exactly one cycle.
- GAP: emits 00 for exactly GAP_LEN cycles, then goes to P1 with num=01.
- Burst length: busy stays high for F·(L1+L2+L3) + (F−1)·GAP_LEN cycles, where F, L1, L2 and L3 are the latched, zero-corrected values.
- Counters:
  - The phase counter reloads on every phase entry.
  - The frame counter decrements at the end of each P3.
  - There is no wrap-around: the maximum lengths are 2^CW−1 and 2^FW−1.
- abort=1 at any edge while busy: next state IDLE, num=00, busy=0, done=0.
- abort has priority over start when both are asserted in the same cycle in IDLE; the block stays idle.
- done is never asserted in the same cycle as busy=1.
- A new start may be accepted in the cycle done is high, since the block is in IDLE. The back-to-back burst then shows num=01 in the next cycle.

Test Plan:
- Reset check: reset asserted mid-P2 (len=3/3/3, frames=1) → num=00, busy=0, done=0 immediately. No done after release. A new start then runs a clean burst.
- Minimal burst: len1=1, len2=1, len3=1, frames=1, start pulse → num sequence 01, 10, 11, then 00. busy high 3 cycles. done high in cycle 4 only.
- Long burst with gap: len 2/3/4, frames=2, GAP_LEN=2 → 01 01 10 10 10 11 11 11 11 00 00, then the frame repeats. busy=20 cycles. Paired detector output high for exactly 4 cycles per frame, twice.
- Zero correction and no gap: len 0/0/2, frames=0, GAP_LEN=0 build → 01, 10, 11, 11. busy=4 cycles.
- Abort and ignored start: start during P1, then abort during P3 of frame 1 of 3 → extra start has no effect. After abort: num=00, busy=0, done never pulses.
- Back-to-back: start held high continuously with len 1/1/1, frames=1 → a new burst begins in the cycle after done. The 01 follows directly after the single 00/done cycle.

Source files
------------

// File: rtl/seq_pattern_gen_if.sv
// Request/stream interface of the 2-bit symbol pattern generator.
// The master side issues burst requests and consumes the symbol stream.
// The slave side is the generator itself.
interface seq_pattern_gen_if #(
  parameter int CW = 4,
  parameter int FW = 4
);
  logic          start;
  logic          abort;
  logic [CW-1:0] len1;
  logic [CW-1:0] len2;
  logic [CW-1:0] len3;
  logic [FW-1:0] frames;
  logic [1:0]    num;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, len1, len2, len3, frames,
    input  num, busy, done
  );

  modport slave (
    input  start, abort, len1, len2, len3, frames,
    output num, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Symbol pattern generator feeding the 01->10->11 sequence detector.
// A start request emits one or more frames of 01 x L1, 10 x L2, 11 x L3,
// optionally separated by GAP_LEN idle 00 symbols. All outputs are registered.
module seq_pattern_gen #(
  parameter int CW      = 4,
  parameter int FW      = 4,
  parameter int GAP_LEN = 2
) (
  input logic             clk,
  input logic             rst_n,
  seq_pattern_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    P1,
    P2,
    P3,
    GAP
  } state_t;

  // Gap counter wide enough to hold GAP_LEN-1; one bit minimum so the
  // no-gap build still has a legal (unused) register.
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_P1   = 2'b01;
  localparam logic [1:0] SYM_P2   = 2'b10;
  localparam logic [1:0] SYM_P3   = 2'b11;

  state_t        state;
  logic [CW-1:0] l1_q;
  logic [CW-1:0] l2_q;
  logic [CW-1:0] l3_q;
  logic [CW-1:0] ph_cnt;
  logic [FW-1:0] frm_cnt;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    num_q;
  logic          busy_q;
  logic          done_q;

  // A zero length would mean an empty phase; treat it as one symbol.
  function automatic logic [CW-1:0] fix_len(input logic [CW-1:0] v);
    return (v == '0) ? CW'(1) : v;
  endfunction

  function automatic logic [FW-1:0] fix_frm(input logic [FW-1:0] v);
    return (v == '0) ? FW'(1) : v;
  endfunction

  // Burst sequencer: phase/frame/gap counting with registered symbol outputs.
  // NOTE: state and outputs update together with non-blocking assignments so
  // every register sees the pre-edge values; the async reset branch clears
  // every register, so nothing powers up undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      l1_q    <= '0;
      l2_q    <= '0;
      l3_q    <= '0;
      ph_cnt  <= '0;
      frm_cnt <= '0;
      gap_cnt <= '0;
      num_q   <= SYM_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        // Cancel wins over everything, including a start while idle.
        state  <= IDLE;
        num_q  <= SYM_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              l1_q    <= fix_len(bus.len1);
              l2_q    <= fix_len(bus.len2);
              l3_q    <= fix_len(bus.len3);
              frm_cnt <= fix_frm(bus.frames);
              ph_cnt  <= fix_len(bus.len1) - 1'b1;
              state   <= P1;
              num_q   <= SYM_P1;
              busy_q  <= 1'b1;
            end
          end

          P1: begin
            if (ph_cnt == '0) begin
              ph_cnt <= l2_q - 1'b1;
              state  <= P2;
              num_q  <= SYM_P2;
            end else begin
              ph_cnt <= ph_cnt - 1'b1;
            end
          end

          P2: begin
            if (ph_cnt == '0) begin
              ph_cnt <= l3_q - 1'b1;
              state  <= P3;
              num_q  <= SYM_P3;
            end else begin
              ph_cnt <= ph_cnt - 1'b1;
            end
          end

          P3: begin
            if (ph_cnt == '0) begin
              frm_cnt <= frm_cnt - 1'b1;
              if (frm_cnt == FW'(1)) begin
                state  <= IDLE;
                num_q  <= SYM_IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else if (GAP_LEN > 0) begin
                gap_cnt <= GW'(GAP_LEN - 1);
                state   <= GAP;
                num_q   <= SYM_IDLE;
              end else begin
                ph_cnt <= l1_q - 1'b1;
                state  <= P1;
                num_q  <= SYM_P1;
              end
            end else begin
              ph_cnt <= ph_cnt - 1'b1;
            end
          end

          GAP: begin
            if (gap_cnt == '0) begin
              ph_cnt <= l1_q - 1'b1;
              state  <= P1;
              num_q  <= SYM_P1;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end

          default: begin
            state  <= IDLE;
            num_q  <= SYM_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.num  = num_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: two builds (GAP_LEN=2 and GAP_LEN=0) share one
// stimulus stream. Per-cycle expected symbols are queued as stimulus is
// issued; a monitor pops one entry per cycle and compares.
module tb_seq_pattern_gen;

  logic clk;
  logic rst_n;

  seq_pattern_gen_if #(.CW(4), .FW(4)) bus ();
  seq_pattern_gen_if #(.CW(4), .FW(4)) bus_ng ();

  seq_pattern_gen #(.CW(4), .FW(4), .GAP_LEN(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  seq_pattern_gen #(.CW(4), .FW(4), .GAP_LEN(0)) u_dut_ng (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_ng.slave)
  );

  assign bus_ng.start  = bus.start;
  assign bus_ng.abort  = bus.abort;
  assign bus_ng.len1   = bus.len1;
  assign bus_ng.len2   = bus.len2;
  assign bus_ng.len3   = bus.len3;
  assign bus_ng.frames = bus.frames;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;     // {num, busy, done}
    int         step;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_ng_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_id  = 0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: num/busy/done got=%b required=%b", name, got, want);
    end
  endtask

  // Trace alphabet: 0 idle, D done pulse, g gap (00 while busy), 1/2/3 symbols.
  function automatic logic [3:0] exp_of(input byte c);
    case (c)
      "D":     return 4'b0001;
      "g":     return 4'b0010;
      "1":     return 4'b0110;
      "2":     return 4'b1010;
      "3":     return 4'b1110;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic set_len(input int l1, input int l2, input int l3, input int f);
    bus.len1   = 4'(l1);
    bus.len2   = 4'(l2);
    bus.len3   = 4'(l3);
    bus.frames = 4'(f);
  endtask

  // ctl: per-cycle control (s start, a abort, b both, anything else none);
  // missing ctl chars mean none. tr / tr_ng: outputs expected after that edge.
  task automatic play(input string ctl, input string tr, input string tr_ng);
    for (int i = 0; i < tr.len(); i++) begin
      byte c;
      exp_t e;
      c = (i < ctl.len()) ? ctl[i] : ".";
      @(negedge clk);
      bus.start = (c == "s") || (c == "b");
      bus.abort = (c == "a") || (c == "b");
      e.step = step_id;
      e.v    = exp_of(tr[i]);
      exp_q.push_back(e);
      e.v    = exp_of(tr_ng[i]);
      exp_ng_q.push_back(e);
      step_id++;
    end
  endtask

  // Monitor: compare one queued expectation per cycle, just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("gap2 step %0d", e.step), {bus.num, bus.busy, bus.done}, e.v);
    end
    if (exp_ng_q.size() > 0) begin
      e = exp_ng_q.pop_front();
      check($sformatf("gap0 step %0d", e.step), {bus_ng.num, bus_ng.busy, bus_ng.done}, e.v);
    end
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_len(0, 0, 0, 0);

    // Reset state while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("reset gap2", {bus.num, bus.busy, bus.done}, 4'b0000);
    check("reset gap0", {bus_ng.num, bus_ng.busy, bus_ng.done}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-P2 of a 3/3/3 burst: outputs clear immediately.
    set_len(3, 3, 3, 1);
    play("s", "11122", "11122");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset gap2", {bus.num, bus.busy, bus.done}, 4'b0000);
    check("async reset gap0", {bus_ng.num, bus_ng.busy, bus_ng.done}, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // No done pulse after release, then a clean burst.
    play("", "00000", "00000");
    play("s", "111222333D0", "111222333D0");

    // Minimal burst 1/1/1 x1.
    set_len(1, 1, 1, 1);
    play("s", "123D0", "123D0");

    // 2/3/4 x2: gap build inserts two 00 symbols, no-gap build runs frames back to back.
    set_len(2, 3, 4, 2);
    play("s", "112223333gg112223333D0", "112223333112223333D000");

    // Zero correction: 0/0/2 with frames=0 acts as 1/1/2 x1.
    set_len(0, 0, 2, 0);
    play("s", "1233D0", "1233D0");

    // Start during P1 ignored, abort during P3 of frame 1 of 3: no done.
    set_len(2, 2, 2, 3);
    play("ss...a", "1122300000", "1122300000");

    // Abort and start together while idle: stays idle.
    play("b", "000", "000");

    // Start held high: next burst begins right after the done cycle.
    set_len(1, 1, 1, 1);
    play("sssssssss", "123D123D123D0", "123D123D123D0");

    // Let the monitor drain; a leftover entry is a failure.
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0 || exp_ng_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: pending=%0d/%0d required=0/0", exp_q.size(), exp_ng_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
